ins_fetch: RTL and testbench

- Instruction fetch stage feeding the decoder.
- Holds the fetch PC and issues one word request at a time to the memory controller/icache.
- Buffers returned instructions with their PC in a small in-order queue, and presents the head {pc, ins} to decode/issue.
- Redirects to a new PC on flush (branch/jump mispredict) and discards any in-flight stale response.

---
 rtl/ins_fetch_pkg.sv | 27 ++
 rtl/ins_queue.sv | 62 ++++++
 rtl/ins_fetch.sv | 100 ++++++++++
 tb/tb_ins_fetch.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, FSM states,
// queue entry layout and a PC alignment helper.
package ins_fetch_pkg;

  localparam int ADDR_LEN  = 32;
  localparam int INS_LEN   = 32;
  localparam int IFQ_WIDTH = 3;

  // Fetch FSM states; at most one memory request is outstanding at a time.
  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_WAIT    = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_e;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [ADDR_LEN-1:0] pc;
    logic [INS_LEN-1:0]  ins;
  } ifq_entry_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [ADDR_LEN-1:0] word_align(input logic [ADDR_LEN-1:0] addr);
    return addr & ~ADDR_LEN'(3);
  endfunction

endpackage

// File: rtl/ins_queue.sv
// In-order FIFO of {pc, ins} entries between fetch and decode.
// All state freezes while rdy_in is low; clear empties the queue and wins
// over push/pop. The head entry reads as zero while the queue is empty.
module ins_queue
  import ins_fetch_pkg::*;
#(
  parameter int WIDTH = IFQ_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  ifq_entry_t       din,
  output ifq_entry_t       dout,
  output logic             full,
  output logic             empty,
  output logic [WIDTH:0]   count
);

  localparam int DEPTH = 1 << WIDTH;

  ifq_entry_t       entries [DEPTH];
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             do_push;
  logic             do_pop;

  assign full    = count[WIDTH];
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : entries[head];

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk_in or posedge rst_in) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        head  <= tail;
        count <= '0;
      end else begin
        if (do_push) tail <= tail + 1'b1;
        if (do_pop)  head <= head + 1'b1;
        count <= count + (WIDTH+1)'(do_push) - (WIDTH+1)'(do_pop);
      end
    end
  end

  // Entry storage written at the tail.
  always_ff @(posedge clk_in) begin
    // NOTE: the array has no reset; dout is masked while empty so stale
    // contents are never visible, and this keeps it mappable to plain RAM.
    if (rdy_in && !clear && do_push) entries[tail] <= din;
  end

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch stage: owns the fetch PC and the single-outstanding
// request FSM, and buffers returned words in ins_queue for decode.
module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter int          QUEUE_WIDTH = IFQ_WIDTH,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_ins,
  input  logic        flush_in,
  input  logic [31:0] flush_pc,
  output logic        out_valid,
  output logic [31:0] out_ins,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  if_state_e              state;
  if_state_e              state_n;
  logic [31:0]            pc;
  logic [31:0]            pc_n;
  logic                   push;
  logic                   pop;
  logic                   q_full;
  logic                   q_empty;
  logic [QUEUE_WIDTH:0]   q_count;
  ifq_entry_t             q_dout;

  assign mem_req   = (state != IF_IDLE);
  assign mem_addr  = pc;
  assign out_valid = (q_count != '0);
  assign out_ins   = q_dout.ins;
  assign out_pc    = q_dout.pc;
  // A flush suppresses the pop so the redirect sees a clean, empty queue.
  assign pop       = !q_empty && out_ready && !flush_in;

  // FSM state and fetch PC registers, frozen while rdy_in is low.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IF_IDLE;
      pc    <= RESET_PC;
    end else if (rdy_in) begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  // Next-state, next-PC and push decision; flush overrides everything.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    state_n = state;
    pc_n    = pc;
    push    = 1'b0;
    unique case (state)
      IF_IDLE: begin
        if (!flush_in && !q_full) state_n = IF_WAIT;
      end
      IF_WAIT: begin
        if (mem_valid) begin
          state_n = IF_IDLE;
          if (!flush_in) begin
            push = 1'b1;
            pc_n = pc + 32'd4;
          end
        end else if (flush_in) begin
          // The request cannot be withdrawn; swallow its response later.
          state_n = IF_DISCARD;
        end
      end
      IF_DISCARD: begin
        if (mem_valid) state_n = IF_IDLE;
      end
      default: state_n = IF_IDLE;
    endcase
    if (flush_in) pc_n = word_align(flush_pc);
  end

  ins_queue #(
    .WIDTH (QUEUE_WIDTH)
  ) u_queue (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .push   (push),
    .pop    (pop),
    .clear  (flush_in),
    .din    ('{pc: pc, ins: mem_ins}),
    .dout   (q_dout),
    .full   (q_full),
    .empty  (q_empty),
    .count  (q_count)
  );

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch. Inputs are driven and outputs sampled on the
// falling clock edge, so each sample reflects the preceding rising edge.
module tb_ins_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_ins;
  logic        flush_in;
  logic [31:0] flush_pc;
  logic        out_valid;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  ins_fetch #(
    .QUEUE_WIDTH (3),
    .RESET_PC    (32'h0)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_ins   (mem_ins),
    .flush_in  (flush_in),
    .flush_pc  (flush_pc),
    .out_valid (out_valid),
    .out_ins   (out_ins),
    .out_pc    (out_pc),
    .out_ready (out_ready)
  );

  // Instruction word the modelled memory returns for a given address.
  function automatic logic [31:0] ins_for(input logic [31:0] addr);
    return 32'hA500_0000 ^ addr;
  endfunction

  task automatic tick();
    @(negedge clk_in);
  endtask

  // Wait (bounded) until a fetch request is visible.
  task automatic wait_req(input string tag);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_req: mem_req=%b required 1 within 20 cycles", tag, mem_req);
    end
  endtask

  // One-cycle memory response strobe.
  task automatic pulse(input logic [31:0] data);
    mem_valid = 1'b1;
    mem_ins   = data;
    tick();
    mem_valid = 1'b0;
    mem_ins   = '0;
  endtask

  task automatic do_reset();
    rst_in    = 1'b1;
    rdy_in    = 1'b1;
    mem_valid = 1'b0;
    mem_ins   = '0;
    flush_in  = 1'b0;
    flush_pc  = '0;
    out_ready = 1'b0;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in    = 1'b1;
    rdy_in    = 1'b1;
    mem_valid = 1'b0;
    mem_ins   = '0;
    flush_in  = 1'b0;
    flush_pc  = '0;
    out_ready = 1'b0;
    tick();
    checks++;
    if ({mem_req, mem_addr, out_valid, out_ins, out_pc} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs: req=%b addr=%h vld=%b ins=%h pc=%h required 0 0 0 0 0",
               mem_req, mem_addr, out_valid, out_ins, out_pc);
    end
    rst_in = 1'b0;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_request: req=%b addr=%h required 1 00000000", mem_req, mem_addr);
    end
    repeat (3) tick();
    checks++;
    if (mem_req !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL request_held: req=%b vld=%b required 1 0", mem_req, out_valid);
    end
    pulse(32'h0000_0013);
    checks++;
    if ({out_valid, out_pc, out_ins, mem_req} !== {1'b1, 32'h0, 32'h0000_0013, 1'b0}) begin
      errors++;
      $display("FAIL first_response: vld=%b pc=%h ins=%h req=%b required 1 00000000 00000013 0",
               out_valid, out_pc, out_ins, mem_req);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
      errors++;
      $display("FAIL second_request: req=%b addr=%h required 1 00000004", mem_req, mem_addr);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wait_req("fill");
      checks++;
      if (mem_addr !== 32'(4 * i)) begin
        errors++;
        $display("FAIL fill_addr[%0d]: addr=%h required %h", i, mem_addr, 32'(4 * i));
      end
      pulse(ins_for(32'(4 * i)));
    end
    repeat (4) tick();
    checks++;
    if ({mem_req, out_valid, out_pc, out_ins} !== {1'b0, 1'b1, 32'h0, ins_for(32'h0)}) begin
      errors++;
      $display("FAIL full_stall: req=%b vld=%b pc=%h ins=%h required 0 1 00000000 %h",
               mem_req, out_valid, out_pc, out_ins, ins_for(32'h0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_pc !== 32'h4 || out_ins !== ins_for(32'h4)) begin
      errors++;
      $display("FAIL full_pop: pc=%h ins=%h required 00000004 %h", out_pc, out_ins, ins_for(32'h4));
    end
    wait_req("refill");
    checks++;
    if (mem_addr !== 32'h20) begin
      errors++;
      $display("FAIL refill_addr: addr=%h required 00000020", mem_addr);
    end
  endtask

  task automatic test_flush_discard();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_req("pre_flush");
      pulse(ins_for(32'(4 * i)));
    end
    wait_req("pre_flush");
    checks++;
    if (mem_addr !== 32'h10) begin
      errors++;
      $display("FAIL pre_flush_addr: addr=%h required 00000010", mem_addr);
    end
    flush_in = 1'b1;
    flush_pc = 32'h1002;
    tick();
    flush_in = 1'b0;
    checks++;
    if ({mem_req, mem_addr, out_valid} !== {1'b1, 32'h1000, 1'b0}) begin
      errors++;
      $display("FAIL discard_state: req=%b addr=%h vld=%b required 1 00001000 0",
               mem_req, mem_addr, out_valid);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL discard_hold: req=%b vld=%b required 1 0", mem_req, out_valid);
    end
    pulse(32'hDEAD_BEEF);
    checks++;
    if (mem_req !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL discard_drop: req=%b vld=%b required 0 0", mem_req, out_valid);
    end
    wait_req("redirect");
    checks++;
    if (mem_addr !== 32'h1000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_req: addr=%h vld=%b required 00001000 0", mem_addr, out_valid);
    end
    tick();
    pulse(ins_for(32'h1000));
    checks++;
    if ({out_valid, out_pc, out_ins} !== {1'b1, 32'h1000, ins_for(32'h1000)}) begin
      errors++;
      $display("FAIL redirect_data: vld=%b pc=%h ins=%h required 1 00001000 %h",
               out_valid, out_pc, out_ins, ins_for(32'h1000));
    end
  endtask

  task automatic test_flush_collide();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wait_req("collide_fill");
      pulse(ins_for(32'(4 * i)));
    end
    wait_req("collide_fill");
    out_ready = 1'b1;
    flush_in  = 1'b1;
    flush_pc  = 32'h200;
    mem_valid = 1'b1;
    mem_ins   = 32'h1234_5678;
    tick();
    out_ready = 1'b0;
    flush_in  = 1'b0;
    mem_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL collide_state: vld=%b req=%b required 0 0", out_valid, mem_req);
    end
    tick();
    checks++;
    if ({mem_req, mem_addr, out_valid} !== {1'b1, 32'h200, 1'b0}) begin
      errors++;
      $display("FAIL collide_redirect: req=%b addr=%h vld=%b required 1 00000200 0",
               mem_req, mem_addr, out_valid);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    wait_req("freeze_fill");
    pulse(ins_for(32'h0));
    wait_req("freeze_fill");
    rdy_in    = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_valid = (i % 2 == 0);
      mem_ins   = 32'hBAD0_0000 | 32'(i);
      tick();
      checks++;
      if ({mem_req, mem_addr, out_valid, out_pc, out_ins} !== {1'b1, 32'h4, 1'b1, 32'h0, ins_for(32'h0)}) begin
        errors++;
        $display("FAIL freeze[%0d]: req=%b addr=%h vld=%b pc=%h ins=%h required 1 00000004 1 00000000 %h",
                 i, mem_req, mem_addr, out_valid, out_pc, out_ins, ins_for(32'h0));
      end
    end
    rdy_in    = 1'b1;
    mem_valid = 1'b0;
    mem_ins   = '0;
    out_ready = 1'b0;
    tick();
    checks++;
    if ({mem_req, mem_addr, out_pc} !== {1'b1, 32'h4, 32'h0}) begin
      errors++;
      $display("FAIL freeze_resume: req=%b addr=%h pc=%h required 1 00000004 00000000",
               mem_req, mem_addr, out_pc);
    end
    pulse(ins_for(32'h4));
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++;
      $display("FAIL freeze_head: vld=%b pc=%h required 1 00000000", out_valid, out_pc);
    end
    wait_req("freeze_next");
    checks++;
    if (mem_addr !== 32'h8) begin
      errors++;
      $display("FAIL freeze_next_addr: addr=%h required 00000008", mem_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_req("stream");
      checks++;
      if (mem_addr !== 32'(4 * i)) begin
        errors++;
        $display("FAIL stream_addr[%0d]: addr=%h required %h", i, mem_addr, 32'(4 * i));
      end
      pulse(ins_for(32'(4 * i)));
      checks++;
      if ({out_valid, out_pc, out_ins} !== {1'b1, 32'(4 * i), ins_for(32'(4 * i))}) begin
        errors++;
        $display("FAIL stream_out[%0d]: vld=%b pc=%h ins=%h required 1 %h %h",
                 i, out_valid, out_pc, out_ins, 32'(4 * i), ins_for(32'(4 * i)));
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stream_pop[%0d]: vld=%b required 0", i, out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      wait_req("b2b_fill");
      pulse(ins_for(32'(4 * i)));
    end
    wait_req("b2b_fill");
    checks++;
    if (mem_addr !== 32'h8) begin
      errors++;
      $display("FAIL b2b_addr: addr=%h required 00000008", mem_addr);
    end
    out_ready = 1'b1;
    mem_valid = 1'b1;
    mem_ins   = ins_for(32'h8);
    tick();
    mem_valid = 1'b0;
    mem_ins   = '0;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, out_pc, out_ins} !== {1'b1, 32'h4, ins_for(32'h4)}) begin
      errors++;
      $display("FAIL b2b_head: vld=%b pc=%h ins=%h required 1 00000004 %h",
               out_valid, out_pc, out_ins, ins_for(32'h4));
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_pc, out_ins} !== {1'b1, 32'h8, ins_for(32'h8)}) begin
      errors++;
      $display("FAIL b2b_second: vld=%b pc=%h ins=%h required 1 00000008 %h",
               out_valid, out_pc, out_ins, ins_for(32'h8));
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: vld=%b required 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_flush_discard();
    test_flush_collide();
    test_freeze();
    test_stream();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
